spi_master_xfer: RTL and testbench
==================================

// Module: spi_master_xfer
// PURPOSE
//  Host-side SPI master (mode 0, MSB first) that drives the slave-side SPI interface.
//  On Start it lowers SS, then shifts out one command byte followed by Len payload bytes read from
//  a tx buffer memory. MISO bytes received during the payload are written to an rx buffer memory.
//  Used by bench and host-bridge logic to issue READ_START/WRITE_START-style packets.
// PARAMETERS
//  AddrBits  12  width of buffer addresses and of Len
//  ClkDiv    4   SysClk cycles per SPI_CLK half-period; legal values >= 1
// PORTS
//  SysClk     in   1         system clock; all logic is on posedge
//  Reset      in   1         asynchronous, active-high reset
//  Start      in   1         request a transfer; sampled only in IDLE
//  Cmd        in   8         command byte; latched when Start is accepted
//  Len        in   AddrBits  payload byte count (0 is legal); latched when Start is accepted
//  Busy       out  1         transfer in progress (state != IDLE)
//  Done       out  1         one-cycle pulse at the end of a transfer
//  SPI_CLK    out  1         serial clock, idles low
//  SPI_MOSI   out  1         serial data to slave
//  SPI_MISO   in   1         serial data from slave
//  SPI_SS     out  1         active-low slave select
//  txMemAddr  out  AddrBits  tx buffer read address; txMemData is valid 1 cycle after address
//  txMemData  in   8         tx buffer read data
//  rcMemAddr  out  AddrBits  rx buffer write address
//  rcMemData  out  8         rx buffer write data
//  rcMemWE    out  1         rx buffer write enable, one cycle per received payload byte
// BEHAVIOUR
//  Reset values (applied asynchronously):
//   SPI_SS=1, SPI_CLK=0, SPI_MOSI=0, Busy=0, Done=0, rcMemWE=0, txMemAddr=0, rcMemAddr=0,
//   state=IDLE. Reset mid-transfer aborts the transfer: SS rises immediately, no Done,
//   no further writes.
//  States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE:  when Start=1, latch Cmd/Len, set txMemAddr=0 and rcMemAddr=0, go to SETUP.
//          Start is ignored in every other state.
//   SETUP: SS=0, CLK=0, MOSI=Cmd[7]; lasts ClkDiv cycles.
//   SHIFT: per bit, CLK is high for ClkDiv cycles, then low for ClkDiv cycles.
//          MISO is sampled on the SysClk edge that drives CLK high->low.
//          MOSI changes to the next bit on that same edge (mode 0: slave samples on rise).
//          Byte 0 is Cmd. Bytes 1..Len are tx mem[0..Len-1].
//          txMemAddr advances by 1 when each payload byte is loaded into the shifter,
//          so the next byte is prefetched during the current byte.
//   HOLD:  after the last bit's low half: SS=0, CLK=0 for ClkDiv cycles, then SS=1.
//   GAP:   SS=1 for ClkDiv cycles; Done=1 in the last GAP cycle; IDLE on the next cycle.
//  Rx path: MISO bits received during Cmd are discarded.
//   In the cycle after the 8th sample of payload byte k, rcMemWE=1, rcMemData=byte k
//   (first bit sampled = bit 7) and rcMemAddr=k. rcMemAddr increments the following cycle.
//  Timing:
//   SS low for exactly (2 + 16*(1+Len))*ClkDiv SysClk cycles.
//   Start to Done = 1 + (3 + 16*(1+Len))*ClkDiv cycles.
//   CLK pulses = 8*(1+Len).
//  Boundaries:
//   Len=0 sends Cmd only, with no rcMemWE.
//   Len=2^AddrBits-1 writes every address except the last; addresses never wrap.
//   Start asserted in the Done cycle is ignored (Busy=1).
//   MOSI is held at the last bit through HOLD and returns to 0 in GAP.
// TESTING
//  1. ClkDiv=2, Cmd=0x03, Len=0 -> MOSI bits 0,0,0,0,0,0,1,1 on CLK rises;
//     SS low 36 cycles; 8 CLK pulses; no rcMemWE; one Done.
//  2. Len=2, tx={A5,3C}, slave returns FF,12,34 -> MOSI bytes 03,A5,3C;
//     writes rc[0]=12 and rc[1]=34 only; txMemAddr ends at 2.
//  3. Start held high through an entire transfer, including the Done cycle -> exactly one transfer;
//     the next transfer starts only from IDLE.
//  4. Reset pulsed during payload byte 1 -> SS=1 and CLK=0 immediately; no further rcMemWE; no Done;
//     a new Start with Len=1 writes rc[0].
//  5. Loopback MISO=MOSI, Len=4, tx={01,80,FF,5A} -> rc={01,80,FF,5A};
//     Start to Done = 1+(3+80)*ClkDiv cycles.
//  6. ClkDiv=1, Len=3 -> CLK high/low 1 cycle each; SS low 66 cycles; data intact; txMemData
//     prefetch is never late.

Source files
------------

// File: rtl/spi_master_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_xfer
//  Purpose  : Host-side SPI master (mode 0, MSB first). On Start it lowers
//             SS, shifts out a command byte followed by Len payload bytes
//             fetched from a tx buffer, and stores the MISO bytes received
//             during the payload into an rx buffer.
//  Ports    : SysClk/Reset       - clock, asynchronous active-high reset
//             Start/Cmd/Len      - transfer request, command byte, byte count
//             Busy/Done          - in-progress flag, end-of-transfer pulse
//             SPI_CLK/MOSI/MISO/SS - serial bus (SS active low)
//             txMemAddr/txMemData  - tx buffer read port (1-cycle latency)
//             rcMemAddr/rcMemData/rcMemWE - rx buffer write port
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_xfer #(
    parameter int AddrBits = 12,
    parameter int ClkDiv   = 4
) (
    input  logic                SysClk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [7:0]          Cmd,
    input  logic [AddrBits-1:0] Len,
    output logic                Busy,
    output logic                Done,
    output logic                SPI_CLK,
    output logic                SPI_MOSI,
    input  logic                SPI_MISO,
    output logic                SPI_SS,
    output logic [AddrBits-1:0] txMemAddr,
    input  logic [7:0]          txMemData,
    output logic [AddrBits-1:0] rcMemAddr,
    output logic [7:0]          rcMemData,
    output logic                rcMemWE
);

    localparam int c_DIV_W = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(ClkDiv - 1);
    // Count value one cycle before the end of a phase; only used when ClkDiv > 1
    localparam logic [c_DIV_W-1:0]  c_DIV_PRE  = c_DIV_W'((ClkDiv > 1) ? ClkDiv - 2 : 0);
    localparam logic [AddrBits-1:0] c_ADDR_ONE = AddrBits'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_DIV_W-1:0]  r_divCnt;
    logic [2:0]          r_bitCnt;
    logic [AddrBits-1:0] r_byteCnt;
    logic [AddrBits-1:0] r_len;
    logic                r_lastBit;   // final bit of final byte has been sampled
    logic [6:0]          r_txShift;   // bits still to send after the one on MOSI
    logic [6:0]          r_rxShift;   // first seven received bits of current byte

    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_divCnt  <= '0;
            r_bitCnt  <= 3'd0;
            r_byteCnt <= '0;
            r_len     <= '0;
            r_lastBit <= 1'b0;
            r_txShift <= 7'd0;
            r_rxShift <= 7'd0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            SPI_CLK   <= 1'b0;
            SPI_MOSI  <= 1'b0;
            SPI_SS    <= 1'b1;
            txMemAddr <= '0;
            rcMemAddr <= '0;
            rcMemData <= 8'd0;
            rcMemWE   <= 1'b0;
        end else begin
            Done    <= 1'b0;
            rcMemWE <= 1'b0;
            // Address moves on only after the write strobe has been seen
            if (rcMemWE) begin
                rcMemAddr <= rcMemAddr + c_ADDR_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_txShift <= Cmd[6:0];
                        SPI_MOSI  <= Cmd[7];
                        r_len     <= Len;
                        txMemAddr <= '0;
                        rcMemAddr <= '0;
                        SPI_SS    <= 1'b0;
                        SPI_CLK   <= 1'b0;
                        r_divCnt  <= '0;
                        r_bitCnt  <= 3'd0;
                        r_byteCnt <= '0;
                        r_lastBit <= 1'b0;
                        Busy      <= 1'b1;
                        r_state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (r_divCnt == c_DIV_LAST) begin
                        r_divCnt <= '0;
                        SPI_CLK  <= 1'b1;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_divCnt <= r_divCnt + c_DIV_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (r_divCnt != c_DIV_LAST) begin
                        r_divCnt <= r_divCnt + c_DIV_W'(1);
                    end else begin
                        r_divCnt <= '0;
                        if (SPI_CLK) begin
                            // Falling edge: sample MISO and present the next MOSI bit
                            SPI_CLK   <= 1'b0;
                            r_rxShift <= {r_rxShift[5:0], SPI_MISO};
                            r_bitCnt  <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7) begin
                                // Byte 0 is the command; its MISO data is dropped
                                if (r_byteCnt != '0) begin
                                    rcMemWE   <= 1'b1;
                                    rcMemData <= {r_rxShift, SPI_MISO};
                                end
                                if (r_byteCnt == r_len) begin
                                    // MOSI keeps the last bit until GAP
                                    r_lastBit <= 1'b1;
                                end else begin
                                    // txMemData was prefetched a whole byte earlier
                                    r_txShift <= txMemData[6:0];
                                    SPI_MOSI  <= txMemData[7];
                                    txMemAddr <= txMemAddr + c_ADDR_ONE;
                                    r_byteCnt <= r_byteCnt + c_ADDR_ONE;
                                end
                            end else begin
                                SPI_MOSI  <= r_txShift[6];
                                r_txShift <= {r_txShift[5:0], 1'b0};
                            end
                        end else if (r_lastBit) begin
                            r_state <= S_HOLD;
                        end else begin
                            SPI_CLK <= 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (r_divCnt == c_DIV_LAST) begin
                        r_divCnt <= '0;
                        SPI_SS   <= 1'b1;
                        SPI_MOSI <= 1'b0;
                        Done     <= (ClkDiv == 1);
                        r_state  <= S_GAP;
                    end else begin
                        r_divCnt <= r_divCnt + c_DIV_W'(1);
                    end
                end

                S_GAP: begin
                    if (r_divCnt == c_DIV_LAST) begin
                        r_divCnt <= '0;
                        Busy     <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_divCnt <= r_divCnt + c_DIV_W'(1);
                        Done     <= (r_divCnt == c_DIV_PRE);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_xfer
//  Purpose  : Directed self-checking bench for spi_master_xfer. Instance A
//             uses ClkDiv=2, instance B uses ClkDiv=1 (both AddrBits=4).
//             A shared slave model and bus monitor follow the selected one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_xfer;

    localparam int AW = 4;

    logic SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    logic          Reset, startA, startB, miso;
    logic [7:0]    cmd;
    logic [AW-1:0] len;

    logic          busyA, doneA, sclkA, mosiA, ssA, weA;
    logic [AW-1:0] txAddrA, rcAddrA;
    logic [7:0]    txDataA, rcDataA;
    logic          busyB, doneB, sclkB, mosiB, ssB, weB;
    logic [AW-1:0] txAddrB, rcAddrB;
    logic [7:0]    txDataB, rcDataB;

    spi_master_xfer #(.AddrBits(AW), .ClkDiv(2)) u_dutA (
        .SysClk(SysClk), .Reset(Reset), .Start(startA), .Cmd(cmd), .Len(len),
        .Busy(busyA), .Done(doneA), .SPI_CLK(sclkA), .SPI_MOSI(mosiA),
        .SPI_MISO(miso), .SPI_SS(ssA), .txMemAddr(txAddrA), .txMemData(txDataA),
        .rcMemAddr(rcAddrA), .rcMemData(rcDataA), .rcMemWE(weA));

    spi_master_xfer #(.AddrBits(AW), .ClkDiv(1)) u_dutB (
        .SysClk(SysClk), .Reset(Reset), .Start(startB), .Cmd(cmd), .Len(len),
        .Busy(busyB), .Done(doneB), .SPI_CLK(sclkB), .SPI_MOSI(mosiB),
        .SPI_MISO(miso), .SPI_SS(ssB), .txMemAddr(txAddrB), .txMemData(txDataB),
        .rcMemAddr(rcAddrB), .rcMemData(rcDataB), .rcMemWE(weB));

    // tx buffer with one cycle read latency
    logic [7:0] txMem [0:15];
    always @(posedge SysClk) begin
        txDataA <= txMem[txAddrA];
        txDataB <= txMem[txAddrB];
    end

    int cyc = 0;
    always @(posedge SysClk) cyc <= cyc + 1;

    // Selected-instance view
    bit            sel, loopback;
    logic          mSclk, mMosi, mSs, mDone, mWe;
    logic [AW-1:0] mRcAddr;
    logic [7:0]    mRcData;
    assign mSclk   = sel ? sclkB   : sclkA;
    assign mMosi   = sel ? mosiB   : mosiA;
    assign mSs     = sel ? ssB     : ssA;
    assign mDone   = sel ? doneB   : doneA;
    assign mWe     = sel ? weB     : weA;
    assign mRcAddr = sel ? rcAddrB : rcAddrA;
    assign mRcData = sel ? rcDataB : rcDataA;

    // Slave: bit n of the byte stream is presented after n CLK falls
    logic [7:0] slvBytes [0:31];
    logic [7:0] slvByte;
    int         slvIdx;
    assign slvByte = slvBytes[slvIdx[7:3]];
    assign miso    = loopback ? mMosi : slvByte[3'd7 - slvIdx[2:0]];

    // Bus monitor, cleared whenever clrSeq changes
    int         clrSeq, seenSeq, clkPulses, highCyc, ssLow, doneCnt, weCnt, mosiBits;
    bit         prevSclk, lastLowMosi;
    logic [7:0] mosiShift;
    logic [7:0] mosiBytes [0:31];
    logic [AW-1:0] wrAddr [0:31];
    logic [7:0] wrData [0:31];

    always @(negedge SysClk) begin
        if (clrSeq != seenSeq) begin
            seenSeq = clrSeq;
            clkPulses = 0; highCyc = 0; ssLow = 0; doneCnt = 0;
            weCnt = 0; mosiBits = 0; slvIdx = 0;
        end else begin
            if (mSclk && !prevSclk) begin
                clkPulses++;
                mosiShift = {mosiShift[6:0], mMosi};
                mosiBits++;
                if (mosiBits % 8 == 0 && mosiBits <= 256) mosiBytes[mosiBits/8 - 1] = mosiShift;
            end
            if (!mSclk && prevSclk) slvIdx++;
            if (mSclk) highCyc++;
            if (!mSs) begin
                ssLow++;
                lastLowMosi = mMosi;
            end
            if (mDone) doneCnt++;
            if (mWe) begin
                if (weCnt < 32) begin
                    wrAddr[weCnt] = mRcAddr;
                    wrData[weCnt] = mRcData;
                end
                weCnt++;
            end
        end
        prevSclk = mSclk;
    end

    int checks = 0;
    int errors = 0;

    // Issues one transfer and returns the inclusive Start-to-Done cycle count
    task automatic run_xfer(input bit useB, input logic [7:0] c, input logic [AW-1:0] l,
                            input bit hold, output int lat, output bit tout);
        int s;
        sel = useB;
        clrSeq++;
        @(negedge SysClk);
        cmd = c;
        len = l;
        if (useB) startB = 1'b1; else startA = 1'b1;
        s = cyc;
        lat = 0;
        tout = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge SysClk);
            if (!hold) begin startA = 1'b0; startB = 1'b0; end
            if (mDone) begin
                lat = cyc - s + 1;
                tout = 1'b0;
                break;
            end
        end
        if (tout) begin startA = 1'b0; startB = 1'b0; end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge SysClk);
        checks++; if (ssA !== 1'b1) begin errors++; $display("FAIL reset_ss: got %b expected 1", ssA); end
        checks++; if (sclkA !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", sclkA); end
        checks++; if (mosiA !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosiA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busyA); end
        checks++; if (doneA !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", doneA); end
        checks++; if (weA !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", weA); end
        checks++; if (txAddrA !== 4'd0) begin errors++; $display("FAIL reset_txaddr: got %0h expected 0", txAddrA); end
        checks++; if (rcAddrA !== 4'd0) begin errors++; $display("FAIL reset_rcaddr: got %0h expected 0", rcAddrA); end
        checks++; if (ssB !== 1'b1) begin errors++; $display("FAIL reset_ssB: got %b expected 1", ssB); end
        Reset = 1'b0;
        @(negedge SysClk);
    endtask

    task automatic test_cmd_only();
        int lat; bit tout;
        loopback = 1'b0;
        for (int i = 0; i < 32; i++) slvBytes[i] = 8'h00;
        run_xfer(1'b0, 8'h03, 4'd0, 1'b0, lat, tout);
        checks++; if (tout) begin errors++; $display("FAIL cmd_timeout: got no Done expected Done"); end
        checks++; if (lat != 39) begin errors++; $display("FAIL cmd_latency: got %0d expected 39", lat); end
        checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL cmd_busy_done: got %b expected 1", busyA); end
        checks++; if (mosiA !== 1'b0) begin errors++; $display("FAIL cmd_mosi_gap: got %b expected 0", mosiA); end
        repeat (3) @(negedge SysClk);
        checks++; if (mosiBytes[0] !== 8'h03) begin errors++; $display("FAIL cmd_mosi: got %0h expected 03", mosiBytes[0]); end
        checks++; if (clkPulses != 8) begin errors++; $display("FAIL cmd_pulses: got %0d expected 8", clkPulses); end
        checks++; if (highCyc != 16) begin errors++; $display("FAIL cmd_high: got %0d expected 16", highCyc); end
        checks++; if (ssLow != 36) begin errors++; $display("FAIL cmd_sslow: got %0d expected 36", ssLow); end
        checks++; if (weCnt != 0) begin errors++; $display("FAIL cmd_we: got %0d expected 0", weCnt); end
        checks++; if (doneCnt != 1) begin errors++; $display("FAIL cmd_donecnt: got %0d expected 1", doneCnt); end
        checks++; if (lastLowMosi !== 1'b1) begin errors++; $display("FAIL cmd_mosi_hold: got %b expected 1", lastLowMosi); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL cmd_idle: got %b expected 0", busyA); end
    endtask

    task automatic test_payload();
        int lat; bit tout;
        txMem[0] = 8'hA5; txMem[1] = 8'h3C;
        slvBytes[0] = 8'hFF; slvBytes[1] = 8'h12; slvBytes[2] = 8'h34;
        run_xfer(1'b0, 8'h03, 4'd2, 1'b0, lat, tout);
        repeat (3) @(negedge SysClk);
        checks++; if (tout) begin errors++; $display("FAIL pay_timeout: got no Done expected Done"); end
        checks++; if (lat != 103) begin errors++; $display("FAIL pay_latency: got %0d expected 103", lat); end
        checks++; if (mosiBytes[0] !== 8'h03) begin errors++; $display("FAIL pay_mosi0: got %0h expected 03", mosiBytes[0]); end
        checks++; if (mosiBytes[1] !== 8'hA5) begin errors++; $display("FAIL pay_mosi1: got %0h expected a5", mosiBytes[1]); end
        checks++; if (mosiBytes[2] !== 8'h3C) begin errors++; $display("FAIL pay_mosi2: got %0h expected 3c", mosiBytes[2]); end
        checks++; if (weCnt != 2) begin errors++; $display("FAIL pay_wecnt: got %0d expected 2", weCnt); end
        checks++; if (wrAddr[0] !== 4'd0 || wrData[0] !== 8'h12) begin errors++; $display("FAIL pay_wr0: got %0h/%0h expected 0/12", wrAddr[0], wrData[0]); end
        checks++; if (wrAddr[1] !== 4'd1 || wrData[1] !== 8'h34) begin errors++; $display("FAIL pay_wr1: got %0h/%0h expected 1/34", wrAddr[1], wrData[1]); end
        checks++; if (txAddrA !== 4'd2) begin errors++; $display("FAIL pay_txaddr: got %0h expected 2", txAddrA); end
        checks++; if (ssLow != 100) begin errors++; $display("FAIL pay_sslow: got %0d expected 100", ssLow); end
    endtask

    task automatic test_start_held();
        int lat; bit tout;
        run_xfer(1'b0, 8'h0B, 4'd1, 1'b1, lat, tout);
        checks++; if (tout) begin errors++; $display("FAIL hold_timeout: got no Done expected Done"); end
        checks++; if (lat != 71) begin errors++; $display("FAIL hold_latency: got %0d expected 71", lat); end
        checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL hold_busy_done: got %b expected 1", busyA); end
        @(negedge SysClk);
        startA = 1'b0;
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL hold_no_restart: got busy %b expected 0", busyA); end
        repeat (20) @(negedge SysClk);
        checks++; if (doneCnt != 1) begin errors++; $display("FAIL hold_donecnt: got %0d expected 1", doneCnt); end
        checks++; if (clkPulses != 16) begin errors++; $display("FAIL hold_pulses: got %0d expected 16", clkPulses); end
        run_xfer(1'b0, 8'h00, 4'd0, 1'b0, lat, tout);
        checks++; if (tout) begin errors++; $display("FAIL hold_next_timeout: got no Done expected Done"); end
    endtask

    task automatic test_reset_abort();
        int lat; bit tout;
        txMem[0] = 8'h11; txMem[1] = 8'h22;
        slvBytes[0] = 8'h00; slvBytes[1] = 8'h5A; slvBytes[2] = 8'hC3;
        sel = 1'b0;
        clrSeq++;
        @(negedge SysClk);
        cmd = 8'h02; len = 4'd2; startA = 1'b1;
        @(negedge SysClk);
        startA = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge SysClk);
            if (clkPulses >= 19) break;
        end
        checks++; if (clkPulses < 19) begin errors++; $display("FAIL abort_reach: got %0d pulses expected 19", clkPulses); end
        #2 Reset = 1'b1;
        #1;
        checks++; if (ssA !== 1'b1) begin errors++; $display("FAIL abort_ss: got %b expected 1", ssA); end
        checks++; if (sclkA !== 1'b0) begin errors++; $display("FAIL abort_clk: got %b expected 0", sclkA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busyA); end
        @(negedge SysClk);
        Reset = 1'b0;
        repeat (200) @(negedge SysClk);
        checks++; if (weCnt != 1) begin errors++; $display("FAIL abort_wecnt: got %0d expected 1", weCnt); end
        checks++; if (wrData[0] !== 8'h5A) begin errors++; $display("FAIL abort_wr0: got %0h expected 5a", wrData[0]); end
        checks++; if (doneCnt != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", doneCnt); end
        slvBytes[1] = 8'h77;
        run_xfer(1'b0, 8'h02, 4'd1, 1'b0, lat, tout);
        repeat (3) @(negedge SysClk);
        checks++; if (tout) begin errors++; $display("FAIL abort_next_timeout: got no Done expected Done"); end
        checks++; if (weCnt != 1) begin errors++; $display("FAIL abort_next_wecnt: got %0d expected 1", weCnt); end
        checks++; if (wrAddr[0] !== 4'd0 || wrData[0] !== 8'h77) begin errors++; $display("FAIL abort_next_wr: got %0h/%0h expected 0/77", wrAddr[0], wrData[0]); end
    endtask

    task automatic test_loopback();
        int lat; bit tout;
        logic [7:0] exp [0:3];
        exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF; exp[3] = 8'h5A;
        for (int i = 0; i < 4; i++) txMem[i] = exp[i];
        loopback = 1'b1;
        run_xfer(1'b0, 8'h9F, 4'd4, 1'b0, lat, tout);
        repeat (3) @(negedge SysClk);
        loopback = 1'b0;
        checks++; if (tout) begin errors++; $display("FAIL loop_timeout: got no Done expected Done"); end
        checks++; if (lat != 167) begin errors++; $display("FAIL loop_latency: got %0d expected 167", lat); end
        checks++; if (weCnt != 4) begin errors++; $display("FAIL loop_wecnt: got %0d expected 4", weCnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wrData[i] !== exp[i] || wrAddr[i] !== AW'(i)) begin
                errors++; $display("FAIL loop_wr%0d: got %0h/%0h expected %0h/%0h", i, wrAddr[i], wrData[i], i, exp[i]);
            end
        end
    endtask

    task automatic test_div1();
        int lat; bit tout;
        txMem[0] = 8'hC3; txMem[1] = 8'h5A; txMem[2] = 8'h96;
        slvBytes[0] = 8'h00; slvBytes[1] = 8'h11; slvBytes[2] = 8'h22; slvBytes[3] = 8'h33;
        run_xfer(1'b1, 8'h02, 4'd3, 1'b0, lat, tout);
        checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL div1_busy_done: got %b expected 1", busyB); end
        repeat (3) @(negedge SysClk);
        checks++; if (tout) begin errors++; $display("FAIL div1_timeout: got no Done expected Done"); end
        checks++; if (lat != 68) begin errors++; $display("FAIL div1_latency: got %0d expected 68", lat); end
        checks++; if (ssLow != 66) begin errors++; $display("FAIL div1_sslow: got %0d expected 66", ssLow); end
        checks++; if (clkPulses != 32) begin errors++; $display("FAIL div1_pulses: got %0d expected 32", clkPulses); end
        checks++; if (highCyc != 32) begin errors++; $display("FAIL div1_high: got %0d expected 32", highCyc); end
        checks++; if (mosiBytes[1] !== 8'hC3 || mosiBytes[2] !== 8'h5A || mosiBytes[3] !== 8'h96) begin
            errors++; $display("FAIL div1_mosi: got %0h %0h %0h expected c3 5a 96", mosiBytes[1], mosiBytes[2], mosiBytes[3]);
        end
        checks++; if (weCnt != 3) begin errors++; $display("FAIL div1_wecnt: got %0d expected 3", weCnt); end
        checks++; if (wrData[0] !== 8'h11 || wrData[1] !== 8'h22 || wrData[2] !== 8'h33 || wrAddr[2] !== 4'd2) begin
            errors++; $display("FAIL div1_wr: got %0h %0h %0h @%0h expected 11 22 33 @2", wrData[0], wrData[1], wrData[2], wrAddr[2]);
        end
    endtask

    task automatic test_max_len();
        int lat; bit tout;
        for (int i = 0; i < 16; i++) txMem[i] = 8'(i * 37 + 5);
        loopback = 1'b1;
        run_xfer(1'b1, 8'hA0, 4'd15, 1'b0, lat, tout);
        repeat (3) @(negedge SysClk);
        loopback = 1'b0;
        checks++; if (tout) begin errors++; $display("FAIL max_timeout: got no Done expected Done"); end
        checks++; if (lat != 260) begin errors++; $display("FAIL max_latency: got %0d expected 260", lat); end
        checks++; if (weCnt != 15) begin errors++; $display("FAIL max_wecnt: got %0d expected 15", weCnt); end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (wrData[i] !== txMem[i] || wrAddr[i] !== AW'(i)) begin
                errors++; $display("FAIL max_wr%0d: got %0h/%0h expected %0h/%0h", i, wrAddr[i], wrData[i], i, txMem[i]);
            end
        end
        checks++; if (txAddrB !== 4'd15) begin errors++; $display("FAIL max_txaddr: got %0h expected f", txAddrB); end
        checks++; if (rcAddrB !== 4'd15) begin errors++; $display("FAIL max_rcaddr: got %0h expected f", rcAddrB); end
    endtask

    initial begin
        Reset = 1'b1; startA = 1'b0; startB = 1'b0; cmd = 8'h00; len = '0;
        sel = 1'b0; loopback = 1'b0; clrSeq = 0; seenSeq = 0;
        for (int i = 0; i < 16; i++) txMem[i] = 8'h00;
        for (int i = 0; i < 32; i++) slvBytes[i] = 8'h00;
        test_reset();
        test_cmd_only();
        test_payload();
        test_start_held();
        test_reset_abort();
        test_loopback();
        test_div1();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
